// File: rtl/ir_dram_loader_if.sv
// Bus bundle between the CTL diag decode / IR DRAM port and the DRAM loader sequencer.
// Vectors are [N-1:0]; DEC-numbered bit k of a word is index (width-1-k).
interface ir_dram_loader_if #(
    parameter int ADDR_BITS  = 9,
    parameter int DATA_WIDTH = 15
);
    logic                  diagStrobe;
    logic [2:0]            diagFunc;
    logic [ADDR_BITS-1:0]  diagData;
    logic [ADDR_BITS-1:0]  dramAddr;
    logic [DATA_WIDTH-1:0] dramDin;
    logic                  dramWe;
    logic [DATA_WIDTH-1:0] dramDout;
    logic                  holdLoadDram;
    logic                  busy;
    logic [DATA_WIDTH-1:0] rdData;
    logic                  errPar;
    logic                  errVerify;
    logic                  errOverrun;
    logic                  addrWrap;

    modport slave (
        input  diagStrobe, diagFunc, diagData, dramDout,
        output dramAddr, dramDin, dramWe, holdLoadDram, busy, rdData,
               errPar, errVerify, errOverrun, addrWrap
    );

    modport master (
        output diagStrobe, diagFunc, diagData, dramDout,
        input  dramAddr, dramDin, dramWe, holdLoadDram, busy, rdData,
               errPar, errVerify, errOverrun, addrWrap
    );
endinterface

// File: rtl/ir_dram_loader.sv
// Diagnostic sequencer that stages, parity-checks, writes and verifies IR dispatch RAM words.
// Word layout (DEC bits 0..14): A[0:2] B[0:2] PAR J[1:4] J[7:10]; DEC bit 0 is the MSB here.
module ir_dram_loader #(
    parameter int ADDR_BITS  = 9,
    parameter int DATA_WIDTH = 15,
    parameter bit VERIFY     = 1'b1
) (
    input  logic                 clk,
    input  logic                 CROBAR,
    ir_dram_loader_if.slave      bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_RDWAIT, S_CHECK, S_INC, S_READ, S_RDCAP
    } state_e;

    typedef enum logic [2:0] {
        F_SETADR = 3'b000, F_LDAB, F_LDJ, F_WRITE, F_READ, F_CLRERR, F_RSVD6, F_RSVD7
    } func_e;

    state_e                state_q, state_d;
    func_e                 func;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0] stage_q, stage_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic                  par_q, par_d;
    logic                  ver_q, ver_d;
    logic                  ovr_q, ovr_d;
    logic                  wrap_q, wrap_d;

    assign func = func_e'(bus.diagFunc);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        stage_d = stage_q;
        rd_d    = rd_q;
        par_d   = par_q;
        ver_d   = ver_q;
        ovr_d   = ovr_q;
        wrap_d  = wrap_q;
        case (state_q)
            S_IDLE: begin
                if (bus.diagStrobe) begin
                    case (func)
                        F_SETADR: addr_d = bus.diagData;
                        F_LDAB:   stage_d[DATA_WIDTH-1 -: 6] = bus.diagData[5:0];
                        F_LDJ:    stage_d[ADDR_BITS-1:0] = bus.diagData;
                        F_WRITE: begin
                            if (^stage_q) state_d = S_WRITE;
                            else          par_d   = 1'b1;
                        end
                        F_READ:   state_d = S_READ;
                        F_CLRERR: begin
                            par_d  = 1'b0;
                            ver_d  = 1'b0;
                            ovr_d  = 1'b0;
                            wrap_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_WRITE:  state_d = VERIFY ? S_RDWAIT : S_INC;
            S_RDWAIT: state_d = S_CHECK;
            S_CHECK: begin
                rd_d = bus.dramDout;
                if (bus.dramDout != stage_q) ver_d = 1'b1;
                state_d = S_INC;
            end
            S_INC: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == '1) wrap_d = 1'b1;
                state_d = S_IDLE;
            end
            // Sync RAM: address is sampled at the end of READ, data captured in RDCAP.
            S_READ:   state_d = S_RDCAP;
            S_RDCAP: begin
                rd_d    = bus.dramDout;
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
        if (bus.diagStrobe && state_q != S_IDLE) ovr_d = 1'b1;
    end

    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            stage_q <= '0;
            rd_q    <= '0;
            par_q   <= 1'b0;
            ver_q   <= 1'b0;
            ovr_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            stage_q <= stage_d;
            rd_q    <= rd_d;
            par_q   <= par_d;
            ver_q   <= ver_d;
            ovr_q   <= ovr_d;
            wrap_q  <= wrap_d;
        end
    end

    // Outputs decode straight from state so reset drops dramWe without a clock.
    assign bus.dramAddr     = addr_q;
    assign bus.dramDin      = stage_q;
    assign bus.dramWe       = (state_q == S_WRITE);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.holdLoadDram = (state_q != S_IDLE);
    assign bus.rdData       = rd_q;
    assign bus.errPar       = par_q;
    assign bus.errVerify    = ver_q;
    assign bus.errOverrun   = ovr_q;
    assign bus.addrWrap     = wrap_q;
endmodule

// File: tb/tb_ir_dram_loader.sv
// Randomized directed bench for ir_dram_loader against a transaction-level loader model.
module tb_ir_dram_loader;
    localparam bit VERIFY = 1'b1;
    localparam logic [14:0] BIT7 = 15'h0080;

    logic clk = 1'b0;
    logic CROBAR;
    always #5 clk = ~clk;

    ir_dram_loader_if #(.ADDR_BITS(9), .DATA_WIDTH(15)) bus ();

    ir_dram_loader #(.ADDR_BITS(9), .DATA_WIDTH(15), .VERIFY(VERIFY)) dut (
        .clk    (clk),
        .CROBAR (CROBAR),
        .bus    (bus)
    );

    // Synchronous DRAM with optional bit-7 readback corruption.
    logic [14:0] mem_dut [512] = '{default: '0};
    logic        corrupt = 1'b0;
    always @(posedge clk) begin
        if (bus.dramWe === 1'b1) mem_dut[bus.dramAddr] <= bus.dramDin;
        bus.dramDout <= mem_dut[bus.dramAddr] ^ (corrupt ? BIT7 : 15'h0);
    end

    int          we_cnt = 0;
    logic [8:0]  we_addr;
    logic [14:0] we_data;
    always @(negedge clk) begin
        if (bus.dramWe === 1'b1) begin
            we_cnt++;
            we_addr = bus.dramAddr;
            we_data = bus.dramDin;
        end
    end

    // Reference model state
    logic [14:0] exp_mem [512] = '{default: '0};
    logic [8:0]  m_addr;
    logic [14:0] m_stage, m_rd;
    logic        m_par, m_ver, m_ovr, m_wrap;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = '0; m_stage = '0; m_rd = '0;
        m_par = 0; m_ver = 0; m_ovr = 0; m_wrap = 0;
    endtask

    function automatic logic [8:0] odd_j(input logic [8:0] d);
        logic [8:0] r;
        r = d;
        if (^{m_stage[14:9], r} == 1'b0) r[8] = ~r[8];
        return r;
    endfunction

    // Issues one strobe at a negedge, runs it to idle, checks everything. Optional
    // SETADR strobe injected at busy cycle ovr_at to provoke an overrun.
    task automatic do_op(input logic [2:0] f, input logic [8:0] d, input int ovr_at);
        int          we0, cyc, exp_cyc;
        bit          wr;
        logic [8:0]  wr_addr;
        we0 = we_cnt; exp_cyc = 0; wr = 0; wr_addr = m_addr;
        bus.diagStrobe = 1'b1; bus.diagFunc = f; bus.diagData = d;
        @(negedge clk);
        bus.diagStrobe = 1'b0;
        case (f)
            3'd0: m_addr = d;
            3'd1: m_stage[14:9] = d[5:0];
            3'd2: m_stage[8:0] = d;
            3'd3: begin
                if (^m_stage) begin
                    wr = 1;
                    exp_mem[m_addr] = m_stage;
                    if (VERIFY) begin
                        m_rd = m_stage ^ (corrupt ? BIT7 : 15'h0);
                        if (corrupt) m_ver = 1;
                    end
                    exp_cyc = VERIFY ? 4 : 2;
                    if (m_addr == 9'd511) m_wrap = 1;
                    m_addr = (m_addr + 1) % 512;
                end else begin
                    m_par = 1;
                end
            end
            3'd4: begin
                m_rd = exp_mem[m_addr] ^ (corrupt ? BIT7 : 15'h0);
                exp_cyc = 2;
            end
            3'd5: begin m_par = 0; m_ver = 0; m_ovr = 0; m_wrap = 0; end
            default: ;
        endcase
        chk("busy_after_strobe", bus.busy, exp_cyc != 0);
        chk("hold_eq_busy", bus.holdLoadDram, exp_cyc != 0);
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 16) begin
            if (cyc == ovr_at) begin
                bus.diagStrobe = 1'b1; bus.diagFunc = 3'd0; bus.diagData = ~wr_addr;
                m_ovr = 1;
            end else begin
                bus.diagStrobe = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        bus.diagStrobe = 1'b0;
        chk("busy_cycles", cyc, exp_cyc);
        chk("we_count", we_cnt - we0, wr ? 1 : 0);
        if (wr) begin
            chk("we_addr", we_addr, wr_addr);
            chk("we_data", we_data, exp_mem[wr_addr]);
        end
        chk("dramWe_idle", bus.dramWe, 1'b0);
        chk("dramAddr", bus.dramAddr, m_addr);
        chk("rdData", bus.rdData, m_rd);
        chk("flags", {bus.errPar, bus.errVerify, bus.errOverrun, bus.addrWrap},
            {m_par, m_ver, m_ovr, m_wrap});
    endtask

    initial begin
        logic [14:0] w0;
        CROBAR = 1'b1;
        bus.diagStrobe = 1'b0; bus.diagFunc = '0; bus.diagData = '0;
        model_reset();
        repeat (3) @(negedge clk);
        CROBAR = 1'b0;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_hold", bus.holdLoadDram, 1'b0);
        chk("rst_we", bus.dramWe, 1'b0);
        chk("rst_addr", bus.dramAddr, 9'd0);
        chk("rst_din", bus.dramDin, 15'd0);
        chk("rst_rd", bus.rdData, 15'd0);
        chk("rst_flags", {bus.errPar, bus.errVerify, bus.errOverrun, bus.addrWrap}, 4'b0);

        // Basic write/verify at 0o123
        do_op(3'd0, 9'o123, -1);
        do_op(3'd1, 9'o45, -1);
        do_op(3'd2, odd_j(9'($urandom)), -1);
        do_op(3'd3, 9'd0, -1);
        chk("t2_addr", bus.dramAddr, 9'o124);

        // Even parity: suppressed write, then clear
        do_op(3'd2, odd_j(9'($urandom)) ^ 9'h100, -1);
        do_op(3'd3, 9'd0, -1);
        chk("t3_errPar", bus.errPar, 1'b1);
        do_op(3'd5, 9'd0, -1);

        // Wrap at 511, then read back address 0
        do_op(3'd0, 9'd0, -1);
        do_op(3'd1, 9'($urandom), -1);
        do_op(3'd2, odd_j(9'($urandom)), -1);
        w0 = m_stage;
        do_op(3'd3, 9'd0, -1);
        do_op(3'd0, 9'o777, -1);
        do_op(3'd1, 9'($urandom), -1);
        do_op(3'd2, odd_j(9'($urandom)), -1);
        do_op(3'd3, 9'd0, -1);
        chk("t4_wrap", bus.addrWrap, 1'b1);
        chk("t4_addr0", bus.dramAddr, 9'd0);
        do_op(3'd4, 9'd0, -1);
        chk("t4_read0", bus.rdData, w0);
        do_op(3'd5, 9'd0, -1);

        // Readback corruption
        corrupt = 1'b1;
        do_op(3'd0, 9'($urandom_range(0, 510)), -1);
        do_op(3'd3, 9'd0, -1);
        corrupt = 1'b0;
        do_op(3'd5, 9'd0, -1);

        // Overrun mid-write
        do_op(3'd0, 9'o200, -1);
        do_op(3'd3, 9'd0, 1);
        chk("t6_ovr", bus.errOverrun, 1'b1);

        // Reset mid-write with a sticky flag set
        bus.diagStrobe = 1'b1; bus.diagFunc = 3'd3; bus.diagData = '0;
        @(negedge clk);
        bus.diagStrobe = 1'b0;
        chk("mid_we_before", bus.dramWe, 1'b1);
        #1 CROBAR = 1'b1;
        #1;
        chk("mid_we_after", bus.dramWe, 1'b0);
        chk("mid_busy", bus.busy, 1'b0);
        chk("mid_addr", bus.dramAddr, 9'd0);
        chk("mid_flags", {bus.errPar, bus.errVerify, bus.errOverrun, bus.addrWrap}, 4'b0);
        @(negedge clk);
        CROBAR = 1'b0;
        model_reset();

        // Random operation mix
        for (int i = 0; i < 60; i++) begin
            logic [2:0] f;
            logic [8:0] d;
            f = 3'($urandom_range(0, 7));
            d = 9'($urandom);
            do_op(f, d, ($urandom_range(0, 9) == 0) ? 2 : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
